// File: rtl/uart_mmio_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: FSM encodings,
// register offsets, STATUS bit positions and the parity helper.
package uart_mmio_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  localparam logic [31:0] UART_TXDATA_OFF = 32'h0000_0000;
  localparam logic [31:0] UART_STATUS_OFF = 32'h0000_0004;

  localparam int STAT_BUSY_BIT = 0;
  localparam int STAT_OVR_BIT  = 1;
  localparam int STAT_PAR_BIT  = 2;

  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_mmio_tx_if.sv
// Data-memory bus leg between the address decoder and the UART transmitter.
interface uart_mmio_tx_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  WrtEn;
  logic [ADDR_WIDTH-1:0] ADDRIn;
  logic [DATA_WIDTH-1:0] WriteData;
  logic [DATA_WIDTH-1:0] ReadData;

  modport master (output WrtEn, output ADDRIn, output WriteData, input ReadData);
  modport slave  (input WrtEn, input ADDRIn, input WriteData, output ReadData);
endinterface

// File: rtl/uart_mmio_tx_baud_gen.sv
// Bit-period counter: runs 0..CLKS_PER_BIT-1 while not cleared and pulses
// tc_o on the last cycle of each bit period.
module uart_mmio_tx_baud_gen #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  output logic tc_o
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CW-1:0] cnt_q;

  assign tc_o = !clr_i && (cnt_q == CW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (reset || clr_i) begin
      cnt_q <= '0;
    end else if (tc_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end
endmodule

// File: rtl/uart_mmio_tx.sv
// Memory-mapped 8N1 UART transmitter (TXDATA at 0x0, STATUS at 0x4).
// Define UART_PARITY_EN to insert an even-parity bit between data and stop.
module uart_mmio_tx
  import uart_mmio_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200
) (
  input  logic           clk,
  input  logic           reset,
  uart_mmio_tx_if.slave  bus,
  output logic           tx,
  output logic           busy
);
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;

`ifdef UART_PARITY_EN
  localparam logic PAR_EN = 1'b1;
  logic parity_q;
`else
  localparam logic PAR_EN = 1'b0;
`endif

  state_e          state_q;
  logic            tx_q;
  logic            busy_q;
  logic            overrun_q;
  logic [7:0]      data_q;
  logic [7:0]      shift_q;
  logic [2:0]      bit_idx_q;
  logic            tc_s;
  logic            wr_txdata_s;
  logic            wr_status_s;
  logic [DATA_WIDTH-1:0] status_s;
  logic            unused_wdata_s;

  assign wr_txdata_s    = bus.WrtEn && (bus.ADDRIn == ADDR_WIDTH'(UART_TXDATA_OFF));
  assign wr_status_s    = bus.WrtEn && (bus.ADDRIn == ADDR_WIDTH'(UART_STATUS_OFF));
  assign unused_wdata_s = ^bus.WriteData[DATA_WIDTH-1:8];
  assign tx             = tx_q;
  assign busy           = busy_q;

  uart_mmio_tx_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk   (clk),
    .reset (reset),
    .clr_i (state_q == ST_IDLE),
    .tc_o  (tc_s)
  );

  always_comb begin
    status_s                = '0;
    status_s[STAT_BUSY_BIT] = busy_q;
    status_s[STAT_OVR_BIT]  = overrun_q;
    status_s[STAT_PAR_BIT]  = PAR_EN;
  end

  always_comb begin
    if (bus.ADDRIn == ADDR_WIDTH'(UART_TXDATA_OFF)) begin
      bus.ReadData = {{(DATA_WIDTH-8){1'b0}}, data_q};
    end else if (bus.ADDRIn == ADDR_WIDTH'(UART_STATUS_OFF)) begin
      bus.ReadData = status_s;
    end else begin
      bus.ReadData = '0;
    end
  end

  // Frame FSM; a TXDATA write outside IDLE (STOP included) only flags overrun.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      data_q    <= 8'h00;
      shift_q   <= 8'h00;
      bit_idx_q <= 3'd0;
`ifdef UART_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      if (wr_txdata_s && (state_q != ST_IDLE)) begin
        overrun_q <= 1'b1;
      end else if (wr_status_s && bus.WriteData[STAT_OVR_BIT]) begin
        overrun_q <= 1'b0;
      end else begin
        overrun_q <= overrun_q;
      end

      case (state_q)
        ST_IDLE: begin
          if (wr_txdata_s) begin
            state_q   <= ST_START;
            tx_q      <= 1'b0;
            busy_q    <= 1'b1;
            data_q    <= bus.WriteData[7:0];
            shift_q   <= bus.WriteData[7:0];
            bit_idx_q <= 3'd0;
`ifdef UART_PARITY_EN
            parity_q  <= even_parity(bus.WriteData[7:0]);
`endif
          end
        end
        ST_START: begin
          if (tc_s) begin
            state_q <= ST_DATA;
            tx_q    <= shift_q[0];
            shift_q <= {1'b0, shift_q[7:1]};
          end
        end
        ST_DATA: begin
          if (tc_s) begin
            if (bit_idx_q == 3'd7) begin
`ifdef UART_PARITY_EN
              state_q <= ST_PARITY;
              tx_q    <= parity_q;
`else
              state_q <= ST_STOP;
              tx_q    <= 1'b1;
`endif
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              tx_q      <= shift_q[0];
              shift_q   <= {1'b0, shift_q[7:1]};
            end
          end
        end
`ifdef UART_PARITY_EN
        ST_PARITY: begin
          if (tc_s) begin
            state_q <= ST_STOP;
            tx_q    <= 1'b1;
          end
        end
`endif
        ST_STOP: begin
          if (tc_s) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            tx_q    <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_mmio_tx.sv
// Self-checking bench for uart_mmio_tx at CLKS_PER_BIT=10; covers parity
// frames as well when built with UART_PARITY_EN.
module tb_uart_mmio_tx;
  localparam int CPB = 10;
`ifdef UART_PARITY_EN
  localparam logic [31:0] PAR_W = 32'h4;
`else
  localparam logic [31:0] PAR_W = 32'h0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic tx;
  logic busy;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   exp_q[$];

  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
  } vec_t;
  vec_t vecs[6];

  uart_mmio_tx_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  uart_mmio_tx #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32),
    .CLK_FREQ   (1000),
    .BAUD       (100)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .tx    (tx),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic rd_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
    bus.ADDRIn = addr;
    #1;
    chk(name, bus.ReadData, exp);
  endtask

  // Drive a one-cycle write starting now; returns at the next falling edge.
  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    bus.WrtEn     = 1'b1;
    bus.ADDRIn    = addr;
    bus.WriteData = data;
    @(negedge clk);
    bus.WrtEn     = 1'b0;
  endtask

  task automatic start_frame(input logic [7:0] b);
    wr(32'h0, {24'h0, b});
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
`ifdef UART_PARITY_EN
    exp_q.push_back(^b);
`endif
    exp_q.push_back(1'b1);
  endtask

  // Called on the first cycle after acceptance; checks every cycle of the frame.
  task automatic check_frame(input string tag);
    int nbits = exp_q.size();
    for (int i = 0; i < nbits; i++) begin
      bit   e   = exp_q.pop_front();
      bit   bad = 1'b0;
      logic gtx = 1'b0;
      logic gbs = 1'b0;
      for (int c = 0; c < CPB; c++) begin
        if (!(i == 0 && c == 0)) @(negedge clk);
        if (!bad && (tx !== e || busy !== 1'b1)) begin
          bad = 1'b1;
          gtx = tx;
          gbs = busy;
        end
      end
      n_cmp++;
      if (bad) begin
        n_err++;
        $display("FAIL %s bit%0d: tx=%b busy=%b expected tx=%b busy=1", tag, i, gtx, gbs, e);
      end
    end
    @(negedge clk);
    chk({tag, " end busy"}, {31'h0, busy}, 32'h0);
    chk({tag, " end tx"}, {31'h0, tx}, 32'h1);
  endtask

  initial begin
    vecs[0] = '{1'b0, 32'h4, 32'h0,  PAR_W};
    vecs[1] = '{1'b0, 32'h0, 32'h0,  32'h0};
    vecs[2] = '{1'b1, 32'h8, 32'hFF, 32'h0};
    vecs[3] = '{1'b0, 32'h8, 32'h0,  32'h0};
    vecs[4] = '{1'b1, 32'h4, 32'h2,  PAR_W};
    vecs[5] = '{1'b0, 32'hC, 32'h0,  32'h0};

    reset = 1'b1;
    bus.WrtEn = 1'b0;
    bus.ADDRIn = 32'h0;
    bus.WriteData = 32'h0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("idle tx", {31'h0, tx}, 32'h1);
    chk("idle busy", {31'h0, busy}, 32'h0);
    rd_chk("idle status", 32'h4, PAR_W);

    // Register map while idle: reads, ignored writes, clear with no overrun.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.WrtEn     = vecs[i].wen;
      bus.ADDRIn    = vecs[i].addr;
      bus.WriteData = vecs[i].wdata;
      #1;
      chk($sformatf("vec%0d rd", i), bus.ReadData, vecs[i].exp_rd);
      @(negedge clk);
      bus.WrtEn = 1'b0;
      chk($sformatf("vec%0d busy", i), {31'h0, busy}, 32'h0);
      chk($sformatf("vec%0d tx", i), {31'h0, tx}, 32'h1);
    end

    // 0xA5 frame with a dropped 0x3C write at N+50.
    @(negedge clk);
    start_frame(8'hA5);
    fork
      check_frame("A5");
      begin
        repeat (49) @(negedge clk);
        wr(32'h0, 32'h3C);
        rd_chk("ovr status", 32'h4, 32'h3 | PAR_W);
        rd_chk("ovr data", 32'h0, 32'hA5);
      end
    join
    wr(32'h4, 32'h2);
    rd_chk("clr status", 32'h4, PAR_W);

    // Reset mid-frame at N+35.
    @(negedge clk);
    start_frame(8'h5A);
    repeat (34) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    chk("rst tx", {31'h0, tx}, 32'h1);
    chk("rst busy", {31'h0, busy}, 32'h0);
    rd_chk("rst data", 32'h0, 32'h0);
    @(negedge clk);
    start_frame(8'h01);
    check_frame("01");

    // Write during the final STOP cycle is dropped; next-cycle write accepted.
    @(negedge clk);
    start_frame(8'h81);
    fork
      check_frame("81");
      begin
        repeat (99) @(negedge clk);
        wr(32'h0, 32'hFF);
      end
    join
    rd_chk("stop ovr status", 32'h4, 32'h2 | PAR_W);
    rd_chk("stop ovr data", 32'h0, 32'h81);
    @(negedge clk);
    start_frame(8'h42);
    check_frame("42");
    rd_chk("after stop data", 32'h0, 32'h42);

`ifdef UART_PARITY_EN
    @(negedge clk);
    start_frame(8'h07);
    check_frame("07par");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
